// File: rtl/stepper_move_scheduler.sv
// Segment FIFO plus launch sequencer that feeds a bank of stepper channels.
// Define STEPPER_SCHED_ABORT_EN to add the abort/flush input.
module stepper_move_scheduler #(
  parameter int AXES  = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef STEPPER_SCHED_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [32*AXES-1:0]     wr_steps,
  input  logic [32*AXES-1:0]     wr_speed,
  output logic [32*AXES-1:0]     step_in,
  output logic [32*AXES-1:0]     speed,
  output logic [AXES-1:0]        start_driving,
  input  logic [AXES-1:0]        stepper_driving,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [31:0]            segments_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = 32 * AXES;

  typedef enum logic [2:0] {SYNC, IDLE, LOAD, START, ARM, BUSY} state_t;

  state_t          state_q;
  logic [SW-1:0]   stepMem_q  [DEPTH];
  logic [SW-1:0]   speedMem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [LW-1:0]   level_q;
  logic [AXES-1:0] mask_q;
  logic [SW-1:0]   stepIn_q, speed_q;
  logic [AXES-1:0] start_q;
  logic            busy_q;
  logic            aborted_q;
  logic [31:0]     segDone_q, segDone_d;

  logic            abortNow;
  logic            push, pop;
  logic [SW-1:0]   headSteps, headSpeed, fixedSpeed;
  logic [AXES-1:0] headMask;

`ifdef STEPPER_SCHED_ABORT_EN
  assign abortNow = abort;
`else
  assign abortNow = 1'b0;
`endif

  assign wr_ready  = (level_q != LW'(DEPTH)) && !abortNow;
  assign push      = wr_valid && wr_ready;
  assign pop       = (state_q == IDLE) && (level_q != '0) && !abortNow;
  assign headSteps = stepMem_q[rdPtr_q];
  assign headSpeed = speedMem_q[rdPtr_q];

  // An axis launches only if its magnitude is non-zero; a zero speed on such an axis would stall it.
  always_comb begin
    headMask   = '0;
    fixedSpeed = headSpeed;
    for (int i = 0; i < AXES; i++) begin
      headMask[i] = (headSteps[32*i +: 31] != 31'd0);
      if (headMask[i] && (headSpeed[32*i +: 32] == 32'd0))
        fixedSpeed[32*i +: 32] = 32'd1;
    end
  end

  always_comb begin
    segDone_d = segDone_q;
    if ((state_q == LOAD) && (mask_q == '0) && !abortNow)
      segDone_d = segDone_q + 32'd1;
    else if ((state_q == BUSY) && ((stepper_driving & mask_q) == '0) && !aborted_q && !abortNow)
      segDone_d = segDone_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stepMem_q[wrPtr_q]  <= wr_steps;
      speedMem_q[wrPtr_q] <= wr_speed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SYNC;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      mask_q    <= '0;
      stepIn_q  <= '0;
      speed_q   <= '0;
      start_q   <= '0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      segDone_q <= '0;
    end else begin
      busy_q    <= (state_q != IDLE) || (level_q != '0);
      start_q   <= '0;
      segDone_q <= segDone_d;
      if (abortNow) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        level_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + 1'b1;
        if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end
      case (state_q)
        SYNC: if (stepper_driving == '0) state_q <= IDLE;
        IDLE: begin
          if (pop) begin
            stepIn_q  <= headSteps;
            speed_q   <= fixedSpeed;
            mask_q    <= headMask;
            aborted_q <= 1'b0;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (abortNow) begin
            aborted_q <= 1'b1;
            state_q   <= BUSY;
          end else if (mask_q == '0) begin
            state_q <= IDLE;
          end else begin
            start_q <= mask_q;
            state_q <= START;
          end
        end
        // The pulse is already out here, so an abort still passes through ARM to let driving rise.
        START: begin
          if (abortNow) aborted_q <= 1'b1;
          state_q <= ARM;
        end
        ARM: begin
          if (abortNow) aborted_q <= 1'b1;
          state_q <= BUSY;
        end
        BUSY: begin
          if ((stepper_driving & mask_q) == '0) state_q <= IDLE;
          else if (abortNow)                    aborted_q <= 1'b1;
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign step_in       = stepIn_q;
  assign speed         = speed_q;
  assign start_driving = start_q;
  assign busy          = busy_q;
  assign fifo_level    = level_q;
  assign segments_done = segDone_q;

endmodule

// File: tb/tb_stepper_move_scheduler.sv
// Self-checking bench for stepper_move_scheduler with simple stepper channel models.
// Exercises the abort path as well when STEPPER_SCHED_ABORT_EN is defined.
module tb_stepper_move_scheduler;
  localparam int AXES  = 4;
  localparam int DEPTH = 8;
  localparam int SW    = 32 * AXES;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [SW-1:0]          wr_steps, wr_speed, step_in, speed;
  logic [AXES-1:0]        start_driving, stepper_driving;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [31:0]            segments_done;
`ifdef STEPPER_SCHED_ABORT_EN
  logic                   abort;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int pushedSegs = 0;
  logic [AXES-1:0] hold;
  int rem [AXES];

  logic [AXES-1:0] logMask[$];
  logic [SW-1:0]   logSteps[$], logSpeed[$];
  int              logCyc[$];
  logic [AXES-1:0] expMask[$];
  logic [SW-1:0]   expSteps[$], expSpeed[$];

  stepper_move_scheduler #(.AXES(AXES), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
`ifdef STEPPER_SCHED_ABORT_EN
    .abort(abort),
`endif
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_steps(wr_steps),
    .wr_speed(wr_speed),
    .step_in(step_in),
    .speed(speed),
    .start_driving(start_driving),
    .stepper_driving(stepper_driving),
    .busy(busy),
    .fifo_level(fifo_level),
    .segments_done(segments_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Channel model: a sampled start keeps the axis driving for a few cycles; hold forces it busy.
  always @(posedge clk) begin
    for (int i = 0; i < AXES; i++) begin
      if (start_driving[i])  rem[i] <= 2 + int'(step_in[32*i +: 3]);
      else if (rem[i] > 0)   rem[i] <= rem[i] - 1;
    end
  end

  always_comb begin
    stepper_driving = '0;
    for (int i = 0; i < AXES; i++) stepper_driving[i] = hold[i] || (rem[i] != 0);
  end

  // Every start pulse is logged with the step/speed words presented alongside it.
  always @(posedge clk) begin
    if (reset !== 1'b1 && start_driving != '0) begin
      logMask.push_back(start_driving);
      logSteps.push_back(step_in);
      logSpeed.push_back(speed);
      logCyc.push_back(cyc);
    end
  end

  function automatic logic [AXES-1:0] refMask(input logic [SW-1:0] st);
    refMask = '0;
    for (int i = 0; i < AXES; i++)
      refMask[i] = ((st >> (32*i)) & SW'(32'h7FFF_FFFF)) != '0;
  endfunction

  function automatic logic [SW-1:0] refSpeed(input logic [SW-1:0] st, input logic [SW-1:0] sp);
    logic [AXES-1:0] m;
    m = refMask(st);
    refSpeed = sp;
    for (int i = 0; i < AXES; i++)
      if (m[i] && sp[32*i +: 32] == 32'd0) refSpeed[32*i +: 32] = 32'd1;
  endfunction

  task automatic clearLogs;
    logMask.delete(); logSteps.delete(); logSpeed.delete(); logCyc.delete();
    expMask.delete(); expSteps.delete(); expSpeed.delete();
    pushedSegs = 0;
  endtask

  task automatic randSeg(output logic [SW-1:0] st, output logic [SW-1:0] sp);
    for (int i = 0; i < AXES; i++) begin
      if ($urandom_range(0, 2) == 0) st[32*i +: 32] = 32'd0;
      else st[32*i +: 32] = {1'($urandom_range(0, 1)), 31'($urandom_range(1, 20))};
      sp[32*i +: 32] = 32'($urandom_range(0, 4));
    end
  endtask

  // Holds wr_valid until the FIFO has room, then records what the model expects to see launched.
  task automatic pushSeg(input logic [SW-1:0] st, input logic [SW-1:0] sp);
    int n = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_steps = st; wr_speed = sp;
    while (wr_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (wr_ready !== 1'b1) begin
      checks++;
      $display("[TB] FAIL push_timeout: wr_ready=%b required 1", wr_ready);
    end else begin
      pushedSegs++;
      if (refMask(st) != '0) begin
        expMask.push_back(refMask(st));
        expSteps.push_back(st);
        expSpeed.push_back(refSpeed(st, sp));
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_valid = 1'b0; wr_steps = '0; wr_speed = '0; hold = '0;
`ifdef STEPPER_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (fifo_level !== '0) $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", wr_ready); else passes++;
    checks++; if (step_in !== '0) $display("[TB] FAIL reset_step_in: got %h want 0", step_in); else passes++;
    checks++; if (speed !== '0) $display("[TB] FAIL reset_speed: got %h want 0", speed); else passes++;
    checks++; if (start_driving !== '0) $display("[TB] FAIL reset_start: got %b want 0", start_driving); else passes++;
    checks++; if (segments_done !== 32'd0) $display("[TB] FAIL reset_done: got %0d want 0", segments_done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passes++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL settle_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_single_segment;
    logic [SW-1:0] st, sp;
    logic [31:0] base;
    int n = 0;
    st = {32'd0, 32'd0, 32'h8000_0003, 32'd5};
    sp = {32'd0, 32'd7, 32'd4, 32'd2};
    clearLogs();
    base = segments_done;
    @(negedge clk);
    wr_valid = 1'b1; wr_steps = st; wr_speed = sp;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_level !== 4'd1) $display("[TB] FAIL single_level: got %0d want 1", fifo_level); else passes++;
    @(negedge clk);
    checks++; if (step_in !== st) $display("[TB] FAIL single_step_in: got %h want %h", step_in, st); else passes++;
    checks++; if (speed !== refSpeed(st, sp)) $display("[TB] FAIL single_speed: got %h want %h", speed, refSpeed(st, sp)); else passes++;
    @(negedge clk);
    checks++; if (start_driving !== 4'b0011) $display("[TB] FAIL single_start: got %b want 0011", start_driving); else passes++;
    @(negedge clk);
    checks++; if (start_driving !== 4'b0000) $display("[TB] FAIL single_start_low: got %b want 0000", start_driving); else passes++;
    while (segments_done !== base + 32'd1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (segments_done !== base + 32'd1) $display("[TB] FAIL single_done: got %0d want %0d", segments_done, base + 32'd1); else passes++;
    checks++; if (logMask.size() != 1) $display("[TB] FAIL single_pulses: got %0d want 1", logMask.size()); else passes++;
    checks++; if (logMask.size() > 0 && logMask[0][2] !== 1'b0) $display("[TB] FAIL single_axis2: got 1 want 0"); else passes++;
  endtask

  task automatic test_zero_segment;
    logic [31:0] base;
    clearLogs();
    base = segments_done;
    @(negedge clk);
    wr_valid = 1'b1; wr_steps = '0; wr_speed = '0;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_level !== 4'd1) $display("[TB] FAIL zero_level: got %0d want 1", fifo_level); else passes++;
    @(negedge clk);
    checks++; if (segments_done !== base) $display("[TB] FAIL zero_early: got %0d want %0d", segments_done, base); else passes++;
    @(negedge clk);
    checks++; if (segments_done !== base + 32'd1) $display("[TB] FAIL zero_done: got %0d want %0d", segments_done, base + 32'd1); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (logMask.size() != 0) $display("[TB] FAIL zero_pulses: got %0d want 0", logMask.size()); else passes++;
  endtask

  task automatic test_fill_drain;
    logic [SW-1:0] st, sp;
    logic [31:0] base;
    int n = 0;
    clearLogs();
    base = segments_done;
    hold = '1;
    randSeg(st, sp);
    st[31:0] = 32'd4;
    pushSeg(st, sp);
    while (logMask.size() < 1 && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < DEPTH; k++) begin
      randSeg(st, sp);
      pushSeg(st, sp);
    end
    @(negedge clk);
    checks++; if (fifo_level !== 4'd8) $display("[TB] FAIL fill_level: got %0d want 8", fifo_level); else passes++;
    checks++; if (wr_ready !== 1'b0) $display("[TB] FAIL fill_ready: got %b want 0", wr_ready); else passes++;
    randSeg(st, sp);
    fork
      pushSeg(st, sp);
      begin
        repeat (4) @(negedge clk);
        checks++; if (fifo_level !== 4'd8) $display("[TB] FAIL fill_retry_level: got %0d want 8", fifo_level); else passes++;
        hold = '0;
      end
    join
    n = 0;
    while (segments_done !== base + 32'(pushedSegs) && n < 2000) begin @(negedge clk); n++; end
    checks++; if (segments_done !== base + 32'(pushedSegs)) $display("[TB] FAIL drain_done: got %0d want %0d", segments_done, base + 32'(pushedSegs)); else passes++;
    checks++; if (logMask.size() != expMask.size()) $display("[TB] FAIL drain_count: got %0d want %0d", logMask.size(), expMask.size()); else passes++;
    for (int k = 0; k < logMask.size() && k < expMask.size(); k++) begin
      checks++; if (logMask[k] !== expMask[k]) $display("[TB] FAIL drain_mask[%0d]: got %b want %b", k, logMask[k], expMask[k]); else passes++;
      checks++; if (logSteps[k] !== expSteps[k]) $display("[TB] FAIL drain_steps[%0d]: got %h want %h", k, logSteps[k], expSteps[k]); else passes++;
      checks++; if (logSpeed[k] !== expSpeed[k]) $display("[TB] FAIL drain_speed[%0d]: got %h want %h", k, logSpeed[k], expSpeed[k]); else passes++;
      if (k > 0) begin
        checks++; if (logCyc[k] - logCyc[k-1] < 3) $display("[TB] FAIL drain_gap[%0d]: got %0d want >=3", k, logCyc[k] - logCyc[k-1]); else passes++;
      end
    end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL drain_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_reset_mid_move;
    logic [SW-1:0] st;
    int n = 0;
    clearLogs();
    hold = 4'b0001;
    pushSeg({32'd0, 32'd0, 32'd0, 32'd3}, {32'd0, 32'd0, 32'd0, 32'd2});
    while (logMask.size() < 1 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (step_in !== '0) $display("[TB] FAIL midrst_step_in: got %h want 0", step_in); else passes++;
    checks++; if (speed !== '0) $display("[TB] FAIL midrst_speed: got %h want 0", speed); else passes++;
    checks++; if (segments_done !== 32'd0) $display("[TB] FAIL midrst_done: got %0d want 0", segments_done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else passes++;
    reset = 1'b0;
    clearLogs();
    st = {32'd0, 32'd0, 32'd6, 32'd0};
    pushSeg(st, {32'd0, 32'd0, 32'd3, 32'd0});
    repeat (10) @(negedge clk);
    checks++; if (logMask.size() != 0) $display("[TB] FAIL midrst_early_start: got %0d pulses want 0", logMask.size()); else passes++;
    checks++; if (fifo_level !== 4'd1) $display("[TB] FAIL midrst_level: got %0d want 1", fifo_level); else passes++;
    hold = '0;
    n = 0;
    while (logMask.size() < 1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (logMask.size() != 1) $display("[TB] FAIL midrst_start: got %0d pulses want 1", logMask.size()); else passes++;
    checks++; if (logMask.size() > 0 && logMask[0] !== refMask(st)) $display("[TB] FAIL midrst_mask: got %b want %b", logMask[0], refMask(st)); else passes++;
    n = 0;
    while (segments_done !== 32'd1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (segments_done !== 32'd1) $display("[TB] FAIL midrst_done_after: got %0d want 1", segments_done); else passes++;
  endtask

  task automatic test_fixup_wrap;
    logic [SW-1:0] st, sp;
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    force dut.segDone_q = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.segDone_q;
    @(negedge clk);
    checks++; if (segments_done !== 32'hFFFF_FFFF) $display("[TB] FAIL wrap_preload: got %h want ffffffff", segments_done); else passes++;
    clearLogs();
    st = {32'h8000_0001, 32'd0, 32'd2, 32'd0};
    sp = {32'd0, 32'd0, 32'd0, 32'd9};
    pushSeg(st, sp);
    n = 0;
    while (segments_done !== 32'd0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (segments_done !== 32'd0) $display("[TB] FAIL wrap_done: got %h want 0", segments_done); else passes++;
    checks++; if (speed[63:32] !== 32'd1) $display("[TB] FAIL fixup_axis1: got %0d want 1", speed[63:32]); else passes++;
    checks++; if (logSpeed.size() > 0 && logSpeed[0] !== expSpeed[0]) $display("[TB] FAIL fixup_speed: got %h want %h", logSpeed[0], expSpeed[0]); else passes++;
  endtask

`ifdef STEPPER_SCHED_ABORT_EN
  task automatic test_abort;
    logic [31:0] base;
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    clearLogs();
    base = segments_done;
    hold = 4'b0001;
    for (int k = 0; k < 3; k++) pushSeg({96'd0, 32'(k + 2)}, {96'd0, 32'd1});
    n = 0;
    while (logMask.size() < 1 && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (fifo_level !== '0) $display("[TB] FAIL abort_level: got %0d want 0", fifo_level); else passes++;
    hold = '0;
    repeat (40) @(negedge clk);
    checks++; if (logMask.size() != 1) $display("[TB] FAIL abort_pulses: got %0d want 1", logMask.size()); else passes++;
    checks++; if (segments_done !== base) $display("[TB] FAIL abort_done: got %0d want %0d", segments_done, base); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_segment();
    test_zero_segment();
    test_fill_drain();
    test_reset_mid_move();
    test_fixup_wrap();
`ifdef STEPPER_SCHED_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/stepper_move_scheduler.md
# stepper_move_scheduler

Sequences queued multi-axis move segments into a bank of `stepper_extruder` channels (X, Y, Z, E). The HPS side pushes segments, each carrying a signed step count and a half-period speed per axis, into a small FIFO. The scheduler launches all axes of a segment together with a `start_driving` pulse, then waits until every launched axis drops `stepper_driving` before launching the next segment. It sits between the HPS bridge registers and the stepper channels.

## Interface
Parameters:
- `AXES`, 4: number of stepper channels driven.
- `DEPTH`, 8: segment FIFO depth; power of two, at least 2.

Ports:
- `clk` in 1: system clock. All logic runs on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_valid` in 1: segment push request.
- `wr_ready` out 1: FIFO not full.
- `wr_steps` in 32*AXES: per-axis step word. Bit 31 is the direction; bits 30:0 hold the count in the stepper's sign format. Axis i occupies [32i+31:32i].
- `wr_speed` in 32*AXES: per-axis half-period in clk cycles.
- `step_in` out 32*AXES: goes to each channel's `stepper_step_in`.
- `speed` out 32*AXES: goes to each channel's `stepper_speed`.
- `start_driving` out AXES: goes to each channel's `start_driving`.
- `stepper_driving` in AXES: comes from each channel's `stepper_driving`.
- `busy` out 1: high when state is not IDLE or the FIFO is not empty.
- `fifo_level` out clog2(DEPTH)+1: number of queued segments.
- `segments_done` out 32: count of completed segments; wraps modulo 2^32.

## Operation
- **FIFO**
  - A push happens when `wr_valid & wr_ready`.
  - A pop happens only in IDLE→LOAD.
  - A simultaneous push and pop leaves the level unchanged.
  - A push while full is ignored; `wr_ready` is 0 then.
  - Read and write pointers wrap modulo DEPTH.
- **Launch mask:** a per-segment register. Bit i = (`wr_steps` axis i bits 30:0 != 0).
- **Speed fix-up:** a speed of 0 on a masked axis is replaced by 1 when loaded.
- **FSM states:** SYNC, IDLE, LOAD, START, ARM, BUSY.
  - SYNC: entered on reset. Leave for IDLE when `stepper_driving` == 0 on all axes. This covers channels that were mid-move at reset; those channels are never stopped.
  - IDLE: if `fifo_level` != 0, pop and go to LOAD.
  - LOAD: register `step_in`, `speed` and the mask from the popped segment. If the mask is 0, increment `segments_done` and go to IDLE. Otherwise go to START.
  - START: `start_driving` = mask for exactly this cycle. Go to ARM.
  - ARM: `start_driving` = 0. Go to BUSY. This cycle exists because a channel's `stepper_driving` rises one cycle after it samples start.
  - BUSY: when (`stepper_driving` & mask) == 0, increment `segments_done` and go to IDLE.
- `step_in` and `speed` hold their values until the next LOAD.
- Unmasked axes get `start_driving` 0 and are ignored in BUSY.
- **Reset values:**
  - FIFO empty, `fifo_level` 0, `wr_ready` 1.
  - `step_in` 0, `speed` 0, `start_driving` 0.
  - `segments_done` 0, `busy` 0, state SYNC.

## Timing
- A push accepted at cycle t into an empty FIFO, with state IDLE:
  - `fifo_level` = 1 at t+1; the pop happens at t+1.
  - `step_in` and `speed` are valid at t+2 (LOAD registered).
  - `start_driving` is high during t+3.
- Back-to-back segments: IDLE is entered the cycle after the last masked `stepper_driving` falls. The next `start_driving` comes 3 cycles after that.
- `start_driving` is always a single-cycle pulse followed by at least 2 low cycles. This clears each channel's rearm flag.
- `busy` is registered; it reflects state and level one cycle late.
- `reset` mid-BUSY: everything resets and the state goes to SYNC. Queued segments are lost. No new start is issued until all channels go idle.

## Configuration
- `STEPPER_SCHED_ABORT_EN` defined:
  - Adds port `abort` in 1.
  - While `abort` is high: FIFO flushed (level 0), pushes ignored, `wr_ready` 0.
  - State LOAD, START or ARM goes to BUSY without asserting `start_driving` if it was not yet pulsed.
  - BUSY completes normally without counting; `segments_done` is not incremented for aborted segments.
  - Abort has priority over a same-cycle push.
- Not defined: there is no `abort` port and the above logic is absent.

## Test plan
- **Single segment.** Reset, then push steps {5, 0x80000003, 0, 0} with speeds {2, 4, 7, 0}.
  - `start_driving` = 4'b0011 in exactly one cycle, 3 cycles after the push.
  - `segments_done` reaches 1 after both axes idle.
  - Axis 2 is never started.
- **All-zero segment.** Push steps {0, 0, 0, 0}.
  - No `start_driving` pulse.
  - `segments_done` increments 2 cycles after the pop.
- **Fill and drain.** Push 9 segments back-to-back with DEPTH=8 and `stepper_driving` held high.
  - `wr_ready` = 0 at level 8; the 9th push is retried and accepted after the first pop.
  - Segments launch in order.
- **Reset mid-move.** Assert `reset` during BUSY while an axis is still driving.
  - Outputs cleared.
  - No `start_driving` until that axis's `stepper_driving` falls, even with a new segment pushed.
- **Speed fix-up and wrap.** Push speed 0 on a masked axis; `speed` output = 1. Preload `segments_done` near 0xFFFFFFFF by forcing; it wraps to 0.
- **Abort (STEPPER_SCHED_ABORT_EN).** Queue 3 segments, then pulse `abort` during the first BUSY.
  - `fifo_level` → 0.
  - The first move completes, with no further `start_driving`.
  - `segments_done` unchanged.
